// File: rtl/stream_arbiter.sv
// Round-robin, packet-aware N:1 stream arbiter with a registered output stage.
// A winner keeps the grant until its last beat is accepted; priority rotates only on last beats.
module stream_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 32,
  parameter int SEL_WIDTH = 2
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [N-1:0]         iValid_AM,
  output logic [N-1:0]         oReady_AM,
  input  logic [N*WIDTH-1:0]   iData_AM,
  input  logic [N-1:0]         iLast_AM,
  output logic                 oValid_BM,
  input  logic                 iReady_BM,
  output logic [WIDTH-1:0]     oData_BM,
  output logic                 oLast_BM,
  output logic [SEL_WIDTH-1:0] oSel_BM,
  output logic                 oDbgLock,
  output logic [SEL_WIDTH-1:0] oDbgPtr,
  output logic [SEL_WIDTH-1:0] oDbgOwner
);

  // Handshake: a beat moves on any port in a cycle where valid and ready are both high at
  // the rising edge; producers hold valid/data until then, and ready never depends on the
  // producer's own valid except through priority selection in IDLE.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [SEL_WIDTH-1:0] r_ptr, w_ptr_nxt;
  logic [SEL_WIDTH-1:0] r_owner, w_owner_nxt;

  logic                 w_ld;
  logic                 w_has;
  logic [SEL_WIDTH-1:0] w_winner;
  logic                 w_lo_found, w_hi_found;
  logic [SEL_WIDTH-1:0] w_lo_idx, w_hi_idx;
  logic [N-1:0]         w_ready;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_acc_data;
  logic                 w_acc_last;

  assign w_ld = ~oValid_BM | iReady_BM;

  // Lowest valid index at or above ptr wins; otherwise the lowest valid index overall.
  always_comb begin
    w_lo_found = 1'b0;
    w_hi_found = 1'b0;
    w_lo_idx   = '0;
    w_hi_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (iValid_AM[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = SEL_WIDTH'(i);
        if (SEL_WIDTH'(i) >= r_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SEL_WIDTH'(i);
        end
      end
    end
    if (r_state == LOCK) begin
      w_has    = 1'b1;
      w_winner = r_owner;
    end else begin
      w_has    = w_lo_found;
      w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end
  end

  always_comb begin
    w_ready    = '0;
    w_acc_data = '0;
    w_acc_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_ready[i] = w_ld & w_has & (w_winner == SEL_WIDTH'(i));
      if (w_ready[i]) begin
        w_acc_data = iData_AM[i*WIDTH +: WIDTH];
        w_acc_last = iLast_AM[i];
      end
    end
  end

  assign w_accept  = |(w_ready & iValid_AM);
  // Reset gating is kept off the internal accept path so the reset only clears state.
  assign oReady_AM = w_ready & ~{N{iRST}};

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    if (w_accept) begin
      if (w_acc_last) begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = (w_winner == SEL_WIDTH'(N - 1)) ? '0 : w_winner + 1'b1;
      end else begin
        w_state_nxt = LOCK;
        w_owner_nxt = w_winner;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oValid_BM <= 1'b0;
      oData_BM  <= '0;
      oLast_BM  <= 1'b0;
      oSel_BM   <= '0;
    end else if (w_ld) begin
      oValid_BM <= w_accept;
      if (w_accept) begin
        oData_BM <= w_acc_data;
        oLast_BM <= w_acc_last;
        oSel_BM  <= w_winner;
      end
    end
  end

  assign oDbgLock  = (r_state == LOCK);
  assign oDbgPtr   = r_ptr;
  assign oDbgOwner = r_owner;

endmodule

// File: tb/tb_stream_arbiter.sv
// Bench for stream_arbiter: directed vector tables, async-reset sequences, and a random
// packet traffic phase checked against a behavioural model and an ordered scoreboard.
module tb_stream_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   valid, ready_o, last;
  logic [N*W-1:0] data;
  logic           ov, rdy_in, ol, dbg_lock;
  logic [W-1:0]   od;
  logic [SW-1:0]  os, dbg_ptr, dbg_owner;

  logic [2:0]  v3, r3, l3;
  logic [23:0] d3;
  logic        ov3, ol3, lk3;
  logic [7:0]  od3;
  logic [1:0]  os3, p3, ow3;

  stream_arbiter #(.N(N), .WIDTH(W), .SEL_WIDTH(SW)) dut (
    .iCLK(clk), .iRST(rst), .iValid_AM(valid), .oReady_AM(ready_o), .iData_AM(data),
    .iLast_AM(last), .oValid_BM(ov), .iReady_BM(rdy_in), .oData_BM(od), .oLast_BM(ol),
    .oSel_BM(os), .oDbgLock(dbg_lock), .oDbgPtr(dbg_ptr), .oDbgOwner(dbg_owner)
  );

  stream_arbiter #(.N(3), .WIDTH(8), .SEL_WIDTH(2)) dut3 (
    .iCLK(clk), .iRST(rst), .iValid_AM(v3), .oReady_AM(r3), .iData_AM(d3),
    .iLast_AM(l3), .oValid_BM(ov3), .iReady_BM(1'b1), .oData_BM(od3), .oLast_BM(ol3),
    .oSel_BM(os3), .oDbgLock(lk3), .oDbgPtr(p3), .oDbgOwner(ow3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model of the arbiter and its output register
  int            m_ptr, m_owner, m_os;
  bit            m_lock, m_ov, m_ol;
  logic [W-1:0]  m_od;
  logic [W+SW:0] exp_q[$];
  int            cnt[N];

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_lock = 0;
    m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
    exp_q.delete();
  endtask

  // Called on the falling edge: compare everything, then advance the model one cycle.
  task automatic step_check(input string tag, output int acc);
    int win;
    bit has, ld;
    logic [N-1:0] er;
    logic [W+SW:0] e;
    ld  = !m_ov || rdy_in;
    has = 0;
    win = 0;
    acc = -1;
    if (m_lock) begin
      has = 1;
      win = m_owner;
    end else begin
      for (int k = 0; k < N; k++)
        if (!has && valid[(m_ptr + k) % N]) begin
          has = 1;
          win = (m_ptr + k) % N;
        end
    end
    er = (ld && has) ? (N'(1) << win) : '0;
    chk($sformatf("%s.ready", tag), ready_o, er);
    chk($sformatf("%s.ovalid", tag), ov, m_ov);
    chk($sformatf("%s.odata", tag), od, m_od);
    chk($sformatf("%s.olast", tag), ol, m_ol);
    chk($sformatf("%s.osel", tag), os, m_os);
    chk($sformatf("%s.ptr", tag), dbg_ptr, m_ptr);
    if (ov && rdy_in) begin
      if (exp_q.size() == 0) chk($sformatf("%s.sb_empty", tag), 1, 0);
      else begin
        e = exp_q.pop_front();
        chk($sformatf("%s.sb_beat", tag), {ol, os, od}, e);
      end
    end
    if (ld) begin
      m_ov = has && valid[win];
      if (m_ov) begin
        acc  = win;
        m_od = data[win*W +: W];
        m_ol = last[win];
        m_os = win;
        exp_q.push_back({last[win], SW'(win), data[win*W +: W]});
        if (last[win]) begin
          m_ptr  = (win + 1) % N;
          m_lock = 0;
        end else begin
          m_owner = win;
          m_lock  = 1;
        end
      end
    end
  endtask

  task automatic drive_cnt_data();
    for (int j = 0; j < N; j++) data[j*W +: W] = 32'hD000_0000 + j * 256 + cnt[j];
  endtask

  // directed vector table
  typedef struct {
    bit         rst;
    logic [3:0] v, l;
    bit         r;
    logic [3:0] er;
    bit         eov;
    logic [1:0] esel;
    bit         elast, elock;
    logic [1:0] eptr;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(bit rs, logic [3:0] v, logic [3:0] l, bit r, logic [3:0] er,
                              bit eov, logic [1:0] esel, bit elast, bit elock, logic [1:0] eptr);
    vec_t t;
    t.rst = rs; t.v = v; t.l = l; t.r = r; t.er = er; t.eov = eov;
    t.esel = esel; t.elast = elast; t.elock = elock; t.eptr = eptr;
    return t;
  endfunction

  // Entered and left at posedge+1.
  task automatic run_table(input string tag);
    int acc;
    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
      end
      valid  = tv[i].v;
      last   = tv[i].l;
      rdy_in = tv[i].r;
      drive_cnt_data();
      @(negedge clk);
      chk($sformatf("%s[%0d].ready", tag, i), ready_o, tv[i].er);
      chk($sformatf("%s[%0d].ovalid", tag, i), ov, tv[i].eov);
      chk($sformatf("%s[%0d].osel", tag, i), os, tv[i].esel);
      chk($sformatf("%s[%0d].olast", tag, i), ol, tv[i].elast);
      chk($sformatf("%s[%0d].lock", tag, i), dbg_lock, tv[i].elock);
      chk($sformatf("%s[%0d].ptr", tag, i), dbg_ptr, tv[i].eptr);
      step_check(tag, acc);
      if (acc >= 0) cnt[acc]++;
      @(posedge clk);
      #1;
    end
  endtask

  // random packet producers
  bit           pv[N], pl[N];
  logic [W-1:0] pd[N];
  int           rem[N];

  initial begin
    int acc;
    rst = 1'b1;
    valid = '0; last = '0; data = '0; rdy_in = 1'b1;
    v3 = 3'b111; l3 = 3'b111; d3 = {8'h32, 8'h31, 8'h30};
    for (int j = 0; j < N; j++) begin
      cnt[j] = 0; pv[j] = 0; pl[j] = 0; pd[j] = '0; rem[j] = 0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ovalid", ov, 0);
    chk("reset.odata", od, 0);
    chk("reset.osel", os, 0);
    chk("reset.ready", ready_o, 0);
    rst = 1'b0;

    // rotation, packet lock, owner gap, backpressure
    tv.push_back(mk(1, 4'b0001, 4'b0001, 1, 4'b0001, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 4'b0010, 4'b0010, 1, 4'b0010, 1, 0, 1, 0, 1));
    tv.push_back(mk(0, 4'b1101, 4'b1001, 1, 4'b0100, 1, 1, 1, 0, 2));
    tv.push_back(mk(0, 4'b1101, 4'b1001, 1, 4'b0100, 1, 2, 0, 1, 2));
    tv.push_back(mk(0, 4'b1101, 4'b1101, 1, 4'b0100, 1, 2, 0, 1, 2));
    tv.push_back(mk(0, 4'b1001, 4'b1001, 1, 4'b1000, 1, 2, 1, 0, 3));
    tv.push_back(mk(0, 4'b0001, 4'b0001, 1, 4'b0001, 1, 3, 1, 0, 0));
    tv.push_back(mk(0, 4'b0011, 4'b0001, 1, 4'b0010, 1, 0, 1, 0, 1));
    tv.push_back(mk(0, 4'b0001, 4'b0001, 1, 4'b0010, 1, 1, 0, 1, 1));
    tv.push_back(mk(0, 4'b0001, 4'b0001, 1, 4'b0010, 0, 1, 0, 1, 1));
    tv.push_back(mk(0, 4'b0011, 4'b0011, 1, 4'b0010, 0, 1, 0, 1, 1));
    tv.push_back(mk(0, 4'b0001, 4'b0001, 1, 4'b0001, 1, 1, 1, 0, 2));
    tv.push_back(mk(0, 4'b0100, 4'b0100, 0, 4'b0000, 1, 0, 1, 0, 1));
    tv.push_back(mk(0, 4'b0100, 4'b0100, 0, 4'b0000, 1, 0, 1, 0, 1));
    tv.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0100, 1, 0, 1, 0, 1));
    tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 2, 1, 0, 3));
    tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 2, 1, 0, 3));
    run_table("tbl_main");
    tv.delete();

    // asynchronous reset mid-cycle with all inputs valid, then single-beat rotation
    valid = 4'b1111; last = 4'b1111; rdy_in = 1'b1;
    drive_cnt_data();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      step_check("pre_rst", acc);
      @(posedge clk);
      #1;
    end
    chk("pre_rst.ovalid_set", ov, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst.ovalid", ov, 0);
    chk("async_rst.odata", od, 0);
    chk("async_rst.olast", ol, 0);
    chk("async_rst.osel", os, 0);
    chk("async_rst.ready", ready_o, 0);
    chk("async_rst.ov3", ov3, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("in_rst.ready", ready_o, 0);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      step_check("rot", acc);
      chk("rot.valid", ov, (k == 0) ? 0 : 1);
      chk("n3.valid", ov3, (k == 0) ? 0 : 1);
      if (k >= 1) begin
        chk("rot.sel", os, (k - 1) % 4);
        chk("n3.sel", os3, (k - 1) % 3);
        chk("n3.data", od3, 8'h30 + 8'((k - 1) % 3));
      end
    end
    @(posedge clk);
    #1;

    // random packet traffic
    valid = '0;
    for (int c = 0; c < 600; c++) begin
      for (int j = 0; j < N; j++) begin
        if (!pv[j]) begin
          if (rem[j] == 0 && $urandom_range(0, 2) == 0) rem[j] = $urandom_range(1, 4);
          if (rem[j] > 0 && $urandom_range(0, 3) != 0) begin
            pv[j] = 1;
            pd[j] = $urandom;
            pl[j] = (rem[j] == 1);
          end
        end
        valid[j]       = pv[j];
        last[j]        = pl[j];
        data[j*W +: W] = pd[j];
      end
      rdy_in = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      step_check("rand", acc);
      if (acc >= 0) begin
        pv[acc] = 0;
        rem[acc]--;
      end
      @(posedge clk);
      #1;
    end
    valid = '0;
    rdy_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      step_check("drain", acc);
      @(posedge clk);
      #1;
    end
    chk("drain.queue_empty", exp_q.size(), 0);

    // reset during beat 2 of a packet from requester 1
    tv.push_back(mk(1, 4'b0010, 4'b0000, 1, 4'b0010, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 4'b0010, 4'b0000, 1, 4'b0010, 1, 1, 0, 1, 0));
    tv.push_back(mk(1, 4'b0011, 4'b0011, 1, 4'b0001, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 1, 0, 1));
    run_table("tbl_rst_mid");
    tv.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
